router_pkt_fifo: RTL and testbench
==================================

ROUTER_PKT_FIFO -- requirements
Module: router_pkt_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data byte width (>=4).
REQ-002 SHALL have parameter DEPTH, default 16, meaning entry count (power of 2, >=4).
REQ-003 SHALL have parameter AFULL_LVL, default 14, meaning fill level at or above which almost_full asserts (1..DEPTH).
REQ-004 SHALL derive AW = log2(DEPTH) internally; fill_level is AW+1 bits wide.
REQ-005 SHALL have ports:
- clock  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- soft_reset  in  1  synchronous flush.
- write_enb  in  1  write request.
- read_enb  in  1  read request.
- lfd_state  in  1  header tag for the current write.
- data_in  in  WIDTH  write data.
- data_out  out  WIDTH  registered read data.
- data_valid  out  1  data_out updated this cycle.
- empty  out  1  no entries held.
- full  out  1  DEPTH entries held.
- almost_full  out  1  fill_level >= AFULL_LVL.
- fill_level  out  AW+1  entries held, 0..DEPTH.
- pkt_done  out  1  one-cycle pulse on last byte of packet read.
- overflow  out  1  one-cycle pulse on rejected write.
- underflow  out  1  one-cycle pulse on rejected read.

Function
REQ-006 SHALL store each entry as WIDTH+1 bits: {lfd_state, data_in}.
REQ-007 SHALL use AW+1-bit read/write pointers: empty when equal; full when MSBs differ and lower AW bits equal.
REQ-008 SHALL accept a write iff write_enb=1 and full=0, storing at write_ptr and incrementing it modulo 2^(AW+1).
REQ-009 SHALL accept a read iff read_enb=1 and empty=0, incrementing read_ptr modulo 2^(AW+1).
REQ-010 SHALL not accept a write when full, even if a read is accepted that cycle.
REQ-011 SHALL, when a read and a write are accepted together, perform both and leave fill_level unchanged.
REQ-012 SHALL load data_out with the WIDTH data bits of the read entry on the edge of an accepted read (1-cycle latency) and assert data_valid for the following cycle only.
REQ-013 SHALL hold data_out unchanged when no read is accepted; it never drives high-impedance.
REQ-014 SHALL register fill_level: +1 on write-only, -1 on read-only, unchanged otherwise.
REQ-015 SHALL derive empty, full and almost_full combinationally from the pointers/fill_level.
REQ-016 SHALL maintain a 7-bit-minimum packet down-counter pkt_cnt, WIDTH-2 bits plus one, so that length+1 cannot wrap.
REQ-017 SHALL, on an accepted read of a tagged entry, load pkt_cnt = data[WIDTH-1:2] + 1 (payload length plus parity byte), with no truncation.
REQ-018 SHALL, on an accepted read of an untagged entry, decrement pkt_cnt if non-zero; it SHALL hold pkt_cnt at 0 otherwise.
REQ-019 SHALL pulse pkt_done for one cycle on the edge where pkt_cnt goes 1->0.
REQ-020 SHALL, if a tagged entry is read while pkt_cnt is non-zero, reload pkt_cnt and raise no pkt_done.
REQ-021 SHALL pulse overflow on the edge after write_enb=1 with full=1; underflow likewise for read_enb=1 with empty=1.

Reset
REQ-022 SHALL, on resetn=0 (asynchronous), clear pointers, fill_level, pkt_cnt, data_out, data_valid, pkt_done, overflow and underflow to 0, giving empty=1, full=0, almost_full=0.
REQ-023 SHALL apply soft_reset=1 on the next clock edge with the same values as REQ-022, overriding any same-cycle read or write.
REQ-024 SHALL not require memory contents to be cleared; stale entries SHALL be unreachable after reset or flush.

Verification
REQ-025 SHALL cover: reset, then 16 writes of 0x01..0x10 with the 17th write_enb held -> full=1 after the 16th, overflow pulse once, fill_level=16, almost_full=1 from fill_level=14.
REQ-026 SHALL cover: drain after REQ-025 -> data_out 0x01..0x10 in order, each 1 cycle after read_enb, empty=1 after the 16th read, extra read -> underflow pulse and data_out stays 0x10.
REQ-027 SHALL cover: header 0x0C tagged (length 3) plus 4 untagged bytes, then all read -> pkt_cnt 4,3,2,1,0 and pkt_done on the 4th untagged read only.
REQ-028 SHALL cover: at fill_level=8, simultaneous read and write for 20 cycles -> fill_level stays 8, pointers wrap past 2^(AW+1), data ordering kept.
REQ-029 SHALL cover: soft_reset mid-packet (pkt_cnt=2, fill_level=5) -> next cycle empty=1, fill_level=0, pkt_cnt=0, data_valid=0, no pkt_done.
REQ-030 SHALL cover: resetn low asynchronously between edges during writes -> outputs clear immediately; with parameters WIDTH=16, DEPTH=64, AFULL_LVL=60, rerun REQ-025..027 with scaled values.

Source files
------------

// File: rtl/router_pkt_fifo_if.sv
// Router packet FIFO bus.
// Groups the write side (write_enb, lfd_state, data_in), the read side
// (read_enb, data_out, data_valid), the flush request (soft_reset) and the
// status/event outputs (empty, full, almost_full, fill_level, pkt_done,
// overflow, underflow). clock and resetn stay plain ports on the FIFO.
//   master : the client driving requests and observing status
//   slave  : the FIFO itself
interface router_pkt_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             soft_reset;
  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic [AW:0]      fill_level;
  logic             pkt_done;
  logic             overflow;
  logic             underflow;

  modport master (
    output soft_reset, write_enb, read_enb, lfd_state, data_in,
    input  data_out, data_valid, empty, full, almost_full, fill_level,
           pkt_done, overflow, underflow
  );

  modport slave (
    input  soft_reset, write_enb, read_enb, lfd_state, data_in,
    output data_out, data_valid, empty, full, almost_full, fill_level,
           pkt_done, overflow, underflow
  );
endinterface

// File: rtl/router_pkt_fifo.sv
// Router packet FIFO.
// Stores {lfd_state, data_in} entries of WIDTH+1 bits in a DEPTH-entry
// circular buffer addressed by AW+1-bit pointers (the extra MSB separates
// full from empty). Reads have one cycle of latency into a registered
// data_out. A header-tagged entry read loads a packet down-counter with
// length+1 (payload plus parity byte); pkt_done pulses when the last byte
// of the packet is read.
// Ports:
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : router_pkt_fifo_if.slave (requests, data, status, event pulses)
module router_pkt_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 14
) (
  input  logic               clock,
  input  logic               resetn,
  router_pkt_fifo_if.slave   bus
);

  localparam int AW  = $clog2(DEPTH);
  // length field is WIDTH-2 bits; one extra bit so length+1 never wraps
  localparam int PCW = (WIDTH - 1 > 7) ? WIDTH - 1 : 7;

  localparam logic [AW:0]     PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]     AFULL_Q = (AW + 1)'(AFULL_LVL);
  localparam logic [PCW-1:0]  CNT_ONE = {{(PCW - 1){1'b0}}, 1'b1};

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      fill_level_q;
  logic [PCW-1:0]   pkt_cnt;
  logic [WIDTH-1:0] data_out_p1;
  logic             vld_p1;
  logic             pkt_done_p1;
  logic             overflow_p1;
  logic             underflow_p1;

  logic             empty_c;
  logic             full_c;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH:0]   rd_entry;
  logic [PCW-1:0]   pkt_cnt_nxt;

  // Packet counter update for one accepted read: a tagged entry reloads
  // with length+1 regardless of the current count; an untagged entry counts
  // down and sticks at zero.
  function automatic logic [PCW-1:0] next_pkt_cnt(input logic [WIDTH:0] entry,
                                                  input logic [PCW-1:0] cur);
    logic [PCW-1:0] len;
    len = {{(PCW - WIDTH + 2){1'b0}}, entry[WIDTH-1:2]};
    if (entry[WIDTH])
      return len + CNT_ONE;
    else if (cur != '0)
      return cur - CNT_ONE;
    else
      return cur;
  endfunction

  assign empty_c  = (wr_ptr == rd_ptr);
  assign full_c   = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // a write is refused when full even if a read frees a slot this cycle
  assign wr_acc   = bus.write_enb & ~full_c;
  assign rd_acc   = bus.read_enb & ~empty_c;
  assign rd_entry = mem[rd_ptr[AW-1:0]];
  assign pkt_cnt_nxt = next_pkt_cnt(rd_entry, pkt_cnt);

  // Storage is never cleared; pointer reset makes old entries unreachable.
  always_ff @(posedge clock) begin
    if (wr_acc)
      mem[wr_ptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
  end

  // ---- stage p0 -> p1: pointer/level update, read data and event pulses ----
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_level_q <= '0;
      pkt_cnt      <= '0;
      data_out_p1  <= '0;
      vld_p1       <= 1'b0;
      pkt_done_p1  <= 1'b0;
      overflow_p1  <= 1'b0;
      underflow_p1 <= 1'b0;
    end else if (bus.soft_reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_level_q <= '0;
      pkt_cnt      <= '0;
      data_out_p1  <= '0;
      vld_p1       <= 1'b0;
      pkt_done_p1  <= 1'b0;
      overflow_p1  <= 1'b0;
      underflow_p1 <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) begin
        rd_ptr      <= rd_ptr + PTR_ONE;
        data_out_p1 <= rd_entry[WIDTH-1:0];
        pkt_cnt     <= pkt_cnt_nxt;
      end
      case ({wr_acc, rd_acc})
        2'b10:   fill_level_q <= fill_level_q + PTR_ONE;
        2'b01:   fill_level_q <= fill_level_q - PTR_ONE;
        default: fill_level_q <= fill_level_q;
      endcase
      vld_p1       <= rd_acc;
      // only an untagged read can take the count from 1 to 0
      pkt_done_p1  <= rd_acc && !rd_entry[WIDTH] && (pkt_cnt == CNT_ONE);
      overflow_p1  <= bus.write_enb & full_c;
      underflow_p1 <= bus.read_enb & empty_c;
    end
  end

  assign bus.data_out    = data_out_p1;
  assign bus.data_valid  = vld_p1;
  assign bus.empty       = empty_c;
  assign bus.full        = full_c;
  assign bus.almost_full = (fill_level_q >= AFULL_Q);
  assign bus.fill_level  = fill_level_q;
  assign bus.pkt_done    = pkt_done_p1;
  assign bus.overflow    = overflow_p1;
  assign bus.underflow   = underflow_p1;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo: one 8-bit/16-entry instance for the
// main scenarios and one 16-bit/64-entry instance for the scaled rerun.
module tb_router_pkt_fifo;

  logic clock;
  logic resetn;
  int   n_cmp;
  int   n_err;

  router_pkt_fifo_if #(.WIDTH(8),  .DEPTH(16)) b1 ();
  router_pkt_fifo_if #(.WIDTH(16), .DEPTH(64)) b2 ();

  router_pkt_fifo #(.WIDTH(8), .DEPTH(16), .AFULL_LVL(14)) u_dut8 (
    .clock (clock),
    .resetn(resetn),
    .bus   (b1)
  );

  router_pkt_fifo #(.WIDTH(16), .DEPTH(64), .AFULL_LVL(60)) u_dut16 (
    .clock (clock),
    .resetn(resetn),
    .bus   (b2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    resetn = 1'b0;
    b1.soft_reset = 0; b1.write_enb = 0; b1.read_enb = 0; b1.lfd_state = 0; b1.data_in = '0;
    b2.soft_reset = 0; b2.write_enb = 0; b2.read_enb = 0; b2.lfd_state = 0; b2.data_in = '0;

    // reset state
    #12;
    chk("rst_empty", b1.empty, 1);
    chk("rst_full", b1.full, 0);
    chk("rst_afull", b1.almost_full, 0);
    chk("rst_fill", b1.fill_level, 0);
    chk("rst_dout", b1.data_out, 0);
    chk("rst_dvalid", b1.data_valid, 0);
    chk("rst_pktcnt", u_dut8.pkt_cnt, 0);
    @(posedge clock); #1;
    resetn = 1'b1;

    // fill 16 entries 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      b1.write_enb = 1; b1.data_in = 8'(i);
      tick();
      chk($sformatf("wr_fill%0d", i), b1.fill_level, i);
      chk($sformatf("wr_afull%0d", i), b1.almost_full, (i >= 14));
      chk($sformatf("wr_full%0d", i), b1.full, (i == 16));
      chk($sformatf("wr_ovf%0d", i), b1.overflow, 0);
    end
    b1.data_in = 8'h11;
    tick();
    chk("ovf_pulse", b1.overflow, 1);
    chk("ovf_fill", b1.fill_level, 16);
    b1.write_enb = 0;
    tick();
    chk("ovf_clear", b1.overflow, 0);

    // drain in order
    for (int i = 1; i <= 16; i++) begin
      b1.read_enb = 1;
      tick();
      chk($sformatf("rd_dout%0d", i), b1.data_out, i);
      chk($sformatf("rd_dvalid%0d", i), b1.data_valid, 1);
      chk($sformatf("rd_fill%0d", i), b1.fill_level, 16 - i);
      chk($sformatf("rd_empty%0d", i), b1.empty, (i == 16));
    end
    tick();
    chk("udf_pulse", b1.underflow, 1);
    chk("udf_dvalid", b1.data_valid, 0);
    chk("udf_dout_hold", b1.data_out, 8'h10);
    b1.read_enb = 0;
    tick();
    chk("udf_clear", b1.underflow, 0);

    // packet: header 0x0C (length 3) plus 4 untagged bytes
    b1.write_enb = 1; b1.lfd_state = 1; b1.data_in = 8'h0C;
    tick();
    b1.lfd_state = 0;
    for (int i = 0; i < 4; i++) begin
      b1.data_in = 8'hA1 + 8'(i);
      tick();
    end
    b1.write_enb = 0;
    b1.read_enb = 1;
    tick();
    chk("pkt_hdr_dout", b1.data_out, 8'h0C);
    chk("pkt_cnt_hdr", u_dut8.pkt_cnt, 4);
    chk("pkt_done_hdr", b1.pkt_done, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("pkt_dout%0d", i), b1.data_out, 8'hA1 + i);
      chk($sformatf("pkt_cnt%0d", i), u_dut8.pkt_cnt, 3 - i);
      chk($sformatf("pkt_done%0d", i), b1.pkt_done, (i == 3));
    end
    b1.read_enb = 0;
    tick();
    chk("pkt_done_after", b1.pkt_done, 0);

    // steady fill of 8 with simultaneous read/write, pointers wrap
    b1.write_enb = 1;
    for (int i = 0; i < 8; i++) begin
      b1.data_in = 8'h40 + 8'(i);
      tick();
    end
    chk("rw_fill_start", b1.fill_level, 8);
    b1.read_enb = 1;
    for (int c = 0; c < 20; c++) begin
      b1.data_in = 8'h48 + 8'(c);
      tick();
      chk($sformatf("rw_dout%0d", c), b1.data_out, 8'h40 + c);
      chk($sformatf("rw_fill%0d", c), b1.fill_level, 8);
    end
    b1.write_enb = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rw_drain%0d", i), b1.data_out, 8'h54 + i);
    end
    b1.read_enb = 0;
    chk("rw_empty", b1.empty, 1);

    // maximum header: 0xFD -> length 63, count 64 without truncation
    b1.write_enb = 1; b1.lfd_state = 1; b1.data_in = 8'hFD;
    tick();
    b1.write_enb = 0; b1.lfd_state = 0; b1.read_enb = 1;
    tick();
    b1.read_enb = 0;
    chk("pkt_cnt_max", u_dut8.pkt_cnt, 64);

    // soft_reset mid-packet: reload from 64 via tagged 0x0C, read 2 more
    b1.write_enb = 1; b1.lfd_state = 1; b1.data_in = 8'h0C;
    tick();
    b1.lfd_state = 0;
    for (int i = 0; i < 7; i++) begin
      b1.data_in = 8'hB0 + 8'(i);
      tick();
    end
    b1.write_enb = 0; b1.read_enb = 1;
    tick();
    chk("sr_reload_cnt", u_dut8.pkt_cnt, 4);
    chk("sr_reload_done", b1.pkt_done, 0);
    tick();
    tick();
    b1.read_enb = 0;
    chk("sr_pre_cnt", u_dut8.pkt_cnt, 2);
    chk("sr_pre_fill", b1.fill_level, 5);
    b1.soft_reset = 1; b1.write_enb = 1; b1.read_enb = 1; b1.data_in = 8'hEE;
    tick();
    chk("sr_empty", b1.empty, 1);
    chk("sr_fill", b1.fill_level, 0);
    chk("sr_cnt", u_dut8.pkt_cnt, 0);
    chk("sr_dvalid", b1.data_valid, 0);
    chk("sr_done", b1.pkt_done, 0);
    chk("sr_dout", b1.data_out, 0);
    b1.soft_reset = 0; b1.write_enb = 0; b1.read_enb = 0;
    tick();
    chk("sr_after_empty", b1.empty, 1);

    // asynchronous reset between edges during writes
    b1.write_enb = 1;
    for (int i = 0; i < 3; i++) begin
      b1.data_in = 8'h71 + 8'(i);
      tick();
    end
    b1.read_enb = 1; b1.data_in = 8'h74;
    tick();
    chk("ar_pre_dout", b1.data_out, 8'h71);
    chk("ar_pre_dvalid", b1.data_valid, 1);
    b1.read_enb = 0;
    #3;
    resetn = 1'b0;
    #1;
    chk("ar_dvalid", b1.data_valid, 0);
    chk("ar_dout", b1.data_out, 0);
    chk("ar_fill", b1.fill_level, 0);
    chk("ar_empty", b1.empty, 1);
    @(posedge clock); #1;
    resetn = 1'b1; b1.write_enb = 0;
    tick();
    chk("ar_after_empty", b1.empty, 1);

    // scaled rerun: WIDTH=16, DEPTH=64, AFULL_LVL=60
    for (int i = 1; i <= 64; i++) begin
      b2.write_enb = 1; b2.data_in = 16'(i * 3 + 16'h100);
      tick();
      chk($sformatf("w16_fill%0d", i), b2.fill_level, i);
      chk($sformatf("w16_afull%0d", i), b2.almost_full, (i >= 60));
      chk($sformatf("w16_full%0d", i), b2.full, (i == 64));
    end
    tick();
    chk("w16_ovf", b2.overflow, 1);
    b2.write_enb = 0;
    tick();
    chk("w16_ovf_clear", b2.overflow, 0);
    b2.read_enb = 1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      chk($sformatf("w16_dout%0d", i), b2.data_out, i * 3 + 16'h100);
    end
    chk("w16_empty", b2.empty, 1);
    tick();
    chk("w16_udf", b2.underflow, 1);
    chk("w16_dout_hold", b2.data_out, 64 * 3 + 16'h100);
    b2.read_enb = 0;

    // scaled packets: max header 0xFFFF -> 0x4000, then 0x0014 -> 6, 6 bytes
    b2.write_enb = 1; b2.lfd_state = 1; b2.data_in = 16'hFFFF;
    tick();
    b2.data_in = 16'h0014;
    tick();
    b2.lfd_state = 0;
    for (int i = 0; i < 6; i++) begin
      b2.data_in = 16'hC000 + 16'(i);
      tick();
    end
    b2.write_enb = 0; b2.read_enb = 1;
    tick();
    chk("w16_cnt_max", u_dut16.pkt_cnt, 32'h4000);
    tick();
    chk("w16_cnt_reload", u_dut16.pkt_cnt, 6);
    chk("w16_done_reload", b2.pkt_done, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("w16_pkt_dout%0d", i), b2.data_out, 16'hC000 + i);
      chk($sformatf("w16_pkt_cnt%0d", i), u_dut16.pkt_cnt, 5 - i);
      chk($sformatf("w16_pkt_done%0d", i), b2.pkt_done, (i == 5));
    end
    b2.read_enb = 0;
    tick();
    chk("w16_done_after", b2.pkt_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
